// File: rtl/gpu_board.sv
// gpu_board: boots a 16x16 8bpp image from SPI flash and scans it to 640x480 VGA.
// Define GPU_BORDER_EN to draw a white one-pixel border around the frame.
module gpu_board (
  input  logic       clk,
  input  logic       reset,
  output logic       cs_n,
  input  logic       sdi,
  output logic       sdo,
  output logic       wp_n,
  output logic       hld_n,
  output logic [3:0] oRed,
  output logic [3:0] oGreen,
  output logic [3:0] oBlue,
  output logic       oHs,
  output logic       oVs
);
  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, DONE
  } fl_state_e;

  logic       loaded;
  logic       ram_we;
  logic [7:0] ram_waddr;
  logic [7:0] ram_wdata;

  assign wp_n  = 1'b1;
  assign hld_n = 1'b1;

  if (1) begin : wb_controller
    if (1) begin : flash
      fl_state_e   state_q, state_d;
      logic        sck, sck_d;
      logic        cs_n_q, cs_n_d;
      logic        sdo_q, sdo_d;
      logic        idle_q, idle_d;
      logic [11:0] cnt_q, cnt_d;
      logic [30:0] tx_q, tx_d;
      logic [6:0]  rx_q, rx_d;
      logic        last;

      // sck high means this edge is a falling edge of sck
      assign last = sck && (cnt_q == 12'd2079);

      always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
      end

      always_comb begin
        state_d = state_q;
        unique case (state_q)
          IDLE: if (idle_q) state_d = CMD;
          CMD:  if (sck && cnt_q == 12'd7) state_d = ADDR;
          ADDR: if (sck && cnt_q == 12'd31) state_d = DATA;
          DATA: if (last) state_d = DONE;
          DONE: state_d = DONE;
          default: state_d = IDLE;
        endcase
      end

      always_comb begin
        idle_d    = 1'b1;
        cs_n_d    = cs_n_q;
        sck_d     = sck;
        sdo_d     = sdo_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        ram_we    = 1'b0;
        ram_waddr = cnt_q[10:3] - 8'd4;
        ram_wdata = {rx_q, sdi};
        unique case (state_q)
          IDLE: if (idle_q) begin
            cs_n_d = 1'b0;
            sck_d  = 1'b0;
            sdo_d  = 1'b0;
            tx_d   = {7'h03, 24'h0};
            cnt_d  = 12'd0;
          end
          CMD, ADDR, DATA: begin
            sck_d = ~sck;
            if (sck) begin
              cnt_d = cnt_q + 12'd1;
              sdo_d = tx_q[30];
              tx_d  = {tx_q[29:0], 1'b0};
              if (last) begin
                cs_n_d = 1'b1;
                sck_d  = 1'b0;
                sdo_d  = 1'b0;
              end
            end else if (state_q == DATA) begin
              rx_d   = {rx_q[5:0], sdi};
              ram_we = (cnt_q[2:0] == 3'd7);
            end
          end
          DONE: begin
            cs_n_d = 1'b1;
            sck_d  = 1'b0;
            sdo_d  = 1'b0;
          end
          default: ;
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          idle_q <= 1'b0;
          cs_n_q <= 1'b1;
          sck    <= 1'b0;
          sdo_q  <= 1'b0;
          cnt_q  <= 12'd0;
          tx_q   <= 31'd0;
          rx_q   <= 7'd0;
        end else begin
          idle_q <= idle_d;
          cs_n_q <= cs_n_d;
          sck    <= sck_d;
          sdo_q  <= sdo_d;
          cnt_q  <= cnt_d;
          tx_q   <= tx_d;
          rx_q   <= rx_d;
        end
      end

      assign cs_n   = cs_n_q;
      assign sdo    = sdo_q;
      assign loaded = (state_q == DONE);
    end
  end

  logic [1:0]  div_q;
  logic        pe;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [5:0]  hsub_q, hsub_d;
  logic [4:0]  vsub_q, vsub_d;
  logic [3:0]  bx_q, bx_d, by_q, by_d;
  logic        vis;
  logic [7:0]  mem_q [256];
  logic [7:0]  rd_q;
  logic        vis1_q, hs1_q, vs1_q;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, vs_q;

  assign pe  = (div_q == 2'd3);
  assign vis = (h_q < 10'd640) && (v_q < 10'd480);

  // block counters track h/40 and v/30 without dividers
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    hsub_d = hsub_q;
    vsub_d = vsub_q;
    bx_d   = bx_q;
    by_d   = by_q;
    if (pe) begin
      if (h_q == 10'd799) begin
        h_d    = 10'd0;
        hsub_d = 6'd0;
        bx_d   = 4'd0;
        if (v_q == 10'd524) begin
          v_d    = 10'd0;
          vsub_d = 5'd0;
          by_d   = 4'd0;
        end else begin
          v_d = v_q + 10'd1;
          if (vsub_q == 5'd29) begin
            vsub_d = 5'd0;
            by_d   = by_q + 4'd1;
          end else begin
            vsub_d = vsub_q + 5'd1;
          end
        end
      end else begin
        h_d = h_q + 10'd1;
        if (hsub_q == 6'd39) begin
          hsub_d = 6'd0;
          bx_d   = bx_q + 4'd1;
        end else begin
          hsub_d = hsub_q + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_waddr] <= ram_wdata;
    rd_q <= mem_q[{by_q, bx_q}];
  end

`ifdef GPU_BORDER_EN
  logic brd, brd1_q;
  assign brd = vis && (h_q == 10'd0 || h_q == 10'd639 ||
                       v_q == 10'd0 || v_q == 10'd479);
  always_ff @(posedge clk) begin
    if (reset) brd1_q <= 1'b0;
    else       brd1_q <= brd;
  end
`endif

  always_comb begin
    rgb_d = 12'h000;
    if (vis1_q && loaded)
      rgb_d = {rd_q[7:5], rd_q[7], rd_q[4:2], rd_q[4],
               rd_q[1:0], rd_q[1:0]};
`ifdef GPU_BORDER_EN
    if (brd1_q) rgb_d = 12'hFFF;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= 2'd0;
      h_q    <= 10'd0;
      v_q    <= 10'd0;
      hsub_q <= 6'd0;
      vsub_q <= 5'd0;
      bx_q   <= 4'd0;
      by_q   <= 4'd0;
      vis1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      rgb_q  <= 12'h000;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
    end else begin
      div_q  <= div_q + 2'd1;
      h_q    <= h_d;
      v_q    <= v_d;
      hsub_q <= hsub_d;
      vsub_q <= vsub_d;
      bx_q   <= bx_d;
      by_q   <= by_d;
      vis1_q <= vis;
      hs1_q  <= !((h_q >= 10'd656) && (h_q <= 10'd751));
      vs1_q  <= !((v_q >= 10'd490) && (v_q <= 10'd491));
      rgb_q  <= rgb_d;
      hs_q   <= hs1_q;
      vs_q   <= vs1_q;
    end
  end

  assign oRed   = rgb_q[11:8];
  assign oGreen = rgb_q[7:4];
  assign oBlue  = rgb_q[3:0];
  assign oHs    = hs_q;
  assign oVs    = vs_q;
endmodule

// File: tb/tb_gpu_board.sv
// tb_gpu_board: flash boot with a scoreboard of expected image bytes,
// reset abort/restart, and VGA line timing/colour checks.
`timescale 1ns/1ps
module tb_gpu_board;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sdi = 1'b0;
  logic       cs_n, sdo, wp_n, hld_n, oHs, oVs;
  logic [3:0] oRed, oGreen, oBlue;

  gpu_board dut (
    .clk   (clk),
    .reset (reset),
    .cs_n  (cs_n),
    .sdi   (sdi),
    .sdo   (sdo),
    .wp_n  (wp_n),
    .hld_n (hld_n),
    .oRed  (oRed),
    .oGreen(oGreen),
    .oBlue (oBlue),
    .oHs   (oHs),
    .oVs   (oVs)
  );

  always #5 clk = ~clk;

`ifdef GPU_BORDER_EN
  localparam logic [11:0] PIX00 = 12'hFFF;
`else
  localparam logic [11:0] PIX00 = 12'h000;
`endif
  localparam logic [11:0] PIX55 = 12'h4B5;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  int          rises, low_cnt, sdo_bad, nbits;
  logic        sck_prev;
  logic [31:0] sdo_word;
  logic [7:0]  cur;
  logic [7:0]  exp_q [$];

  // flash model: sdi toggles after every sck rise; bytes pushed as driven
  always @(negedge clk) begin
    if (reset) begin
      rises = 0; low_cnt = 0; sdo_bad = 0; nbits = 0;
      sdo_word = 0; cur = 0; sdi = 1'b0; sck_prev = 1'b0;
      exp_q.delete();
    end else begin
      if (!cs_n) low_cnt++;
      if (dut.wb_controller.flash.sck && !sck_prev) begin
        rises++;
        if (rises <= 32) begin
          sdo_word = {sdo_word[30:0], sdo};
        end else begin
          if (sdo) sdo_bad++;
          cur = {cur[6:0], sdi};
          nbits++;
          if (nbits % 8 == 0) exp_q.push_back(cur);
        end
        sdi = ~sdi;
      end
      sck_prev = dut.wb_controller.flash.sck;
    end
  end

  task automatic release_chk(input string tag);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk({tag, "_cs_hi_e1"}, cs_n, 1'b1);
    @(negedge clk);
    chk({tag, "_cs_lo_e2"}, cs_n, 1'b0);
    chk({tag, "_sdo_first"}, sdo, 1'b0);
    chk({tag, "_pix00"}, {oRed, oGreen, oBlue}, PIX00);
  endtask

  task automatic line_chk(input string tag);
    int guard = 0;
    int hs_low = 0, vs_low = 0, bad = 0, vis = 0;
    logic [11:0] rgb, want;
    while (oHs === 1'b0 && guard < 4000) begin
      @(negedge clk); guard++;
    end
    while (oHs === 1'b1 && guard < 8000) begin
      @(negedge clk); guard++;
    end
    chk({tag, "_hs_found"}, (guard < 8000), 1'b1);
    for (int k = 0; k < 3200; k++) begin
      rgb = {oRed, oGreen, oBlue};
      if (!oHs) hs_low++;
      if (!oVs) vs_low++;
      want = (k >= 576 && k < 3136) ? PIX55 : 12'h000;
`ifdef GPU_BORDER_EN
      if ((k >= 576 && k < 580) || (k >= 3132 && k < 3136)) want = 12'hFFF;
`endif
      if (rgb !== want) bad++;
      if (want != 12'h000 && rgb === want) vis++;
      @(negedge clk);
    end
    chk({tag, "_hs_low"}, hs_low, 384);
    chk({tag, "_vs_low"}, vs_low, 0);
    chk({tag, "_rgb_bad"}, bad, 0);
    chk({tag, "_rgb_vis"}, vis, 2560);
    chk({tag, "_period"}, oHs, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sdo", sdo, 1'b0);
    chk("rst_sck", dut.wb_controller.flash.sck, 1'b0);
    chk("rst_wp_n", wp_n, 1'b1);
    chk("rst_hld_n", hld_n, 1'b1);
    chk("rst_rgb", {oRed, oGreen, oBlue}, 12'h000);
    chk("rst_hs", oHs, 1'b1);
    chk("rst_vs", oVs, 1'b1);

    release_chk("boot");
    repeat (999) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", cs_n, 1'b1);
    chk("abort_sck", dut.wb_controller.flash.sck, 1'b0);
    release_chk("reload");

    for (int i = 0; i < 5000 && cs_n !== 1'b1; i++) @(negedge clk);
    chk("load_done", cs_n, 1'b1);
    chk("cs_low_clks", low_cnt, 4160);
    chk("sck_rises", rises, 2080);
    chk("sdo_cmd_addr", sdo_word, 32'h0300_0000);
    chk("sdo_data_zero", sdo_bad, 0);
    chk("sck_idle", dut.wb_controller.flash.sck, 1'b0);
    chk("loaded", dut.loaded, 1'b1);
    chk("sb_count", exp_q.size(), 256);
    for (int i = 0; i < 256 && exp_q.size() > 0; i++)
      chk($sformatf("ram[%0d]", i), dut.mem_q[i], exp_q.pop_front());

    line_chk("line_a");
    line_chk("line_b");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
